// File: rtl/ialu_exec_pkg.sv
// Shared core definitions: ALU control decoder codes, execute-stage FSM states and datapath helpers.
// The same codes are used whether or not IALU_BARREL_SHIFT_EN is defined.
package ialu_exec_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_CTL_ADD    = 5'd0;
    localparam logic [4:0] ALU_CTL_SUB    = 5'd1;
    localparam logic [4:0] ALU_CTL_AND    = 5'd2;
    localparam logic [4:0] ALU_CTL_OR     = 5'd3;
    localparam logic [4:0] ALU_CTL_XOR    = 5'd4;
    localparam logic [4:0] ALU_CTL_SLT    = 5'd5;
    localparam logic [4:0] ALU_CTL_SLTU   = 5'd6;
    localparam logic [4:0] ALU_CTL_SLL    = 5'd7;
    localparam logic [4:0] ALU_CTL_SRL    = 5'd8;
    localparam logic [4:0] ALU_CTL_SRA    = 5'd9;
    localparam logic [4:0] ALU_CTL_PASS_B = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == ALU_CTL_SLL) || (op == ALU_CTL_SRL) || (op == ALU_CTL_SRA);
    endfunction

    // Single-cycle ops; shift codes and undefined codes yield zero here.
    function automatic logic [XLEN-1:0] alu_compute(input logic [4:0] op,
                                                    input logic [XLEN-1:0] x,
                                                    input logic [XLEN-1:0] y);
        case (op)
            ALU_CTL_ADD:    return x + y;
            ALU_CTL_SUB:    return x - y;
            ALU_CTL_AND:    return x & y;
            ALU_CTL_OR:     return x | y;
            ALU_CTL_XOR:    return x ^ y;
            ALU_CTL_SLT:    return {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_CTL_SLTU:   return {{(XLEN-1){1'b0}}, (x < y)};
            ALU_CTL_PASS_B: return y;
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/ialu_shifter.sv
// Serial one-bit-per-cycle shifter: holds the operand, remaining count, direction and fill bit.
module ialu_shifter
    import ialu_exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] load_data,
    input  logic [4:0]      load_count,
    input  logic            load_left,
    input  logic            load_arith,
    output logic [4:0]      count,
    output logic [XLEN-1:0] step_data
);

    logic [XLEN-1:0] data_reg;
    logic [4:0]      count_reg;
    logic            left_reg;
    logic            fill_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            count_reg <= '0;
            left_reg  <= 1'b0;
            fill_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            count_reg <= load_count;
            left_reg  <= load_left;
            fill_reg  <= load_arith & load_data[XLEN-1];
        end else if (step && (count_reg != 5'd0)) begin
            data_reg  <= step_data;
            count_reg <= count_reg - 5'd1;
        end
    end

    // Value after one more bit position; the FSM captures it on the final step.
    assign step_data = left_reg ? {data_reg[XLEN-2:0], 1'b0} : {fill_reg, data_reg[XLEN-1:1]};
    assign count     = count_reg;

endmodule

// File: rtl/ialu_exec.sv
// Integer ALU execute stage with valid/ready handshakes; shifts are serial unless
// IALU_BARREL_SHIFT_EN is defined, in which case every op completes in one cycle.
module ialu_exec
    import ialu_exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      aluControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result
);

    state_t          state_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] result_reg;

    logic            accept;
    logic [4:0]      shamt;
    state_t          start_state;
    logic [XLEN-1:0] start_result;

    assign inReady = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && outReady);
    assign accept  = inValid && inReady;
    assign shamt   = b[4:0];

    always_comb begin
        start_state  = ST_DONE;
        start_result = alu_compute(aluControl, a, b);
`ifdef IALU_BARREL_SHIFT_EN
        if (aluControl == ALU_CTL_SLL) start_result = a << shamt;
        if (aluControl == ALU_CTL_SRL) start_result = a >> shamt;
        if (aluControl == ALU_CTL_SRA) start_result = $unsigned($signed(a) >>> shamt);
`else
        // A zero-distance shift is just a pass-through of a.
        if (is_shift_op(aluControl)) begin
            start_result = a;
            if (shamt != 5'd0) start_state = ST_SHIFT;
        end
`endif
    end

`ifndef IALU_BARREL_SHIFT_EN
    logic [4:0]      sh_count;
    logic [XLEN-1:0] sh_step_data;

    ialu_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && (start_state == ST_SHIFT)),
        .step       (state_reg == ST_SHIFT),
        .load_data  (a),
        .load_count (shamt),
        .load_left  (aluControl == ALU_CTL_SLL),
        .load_arith (aluControl == ALU_CTL_SRA),
        .count      (sh_count),
        .step_data  (sh_step_data)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= start_state;
                        out_valid_reg <= (start_state == ST_DONE);
                        result_reg    <= start_result;
                    end
                end
`ifndef IALU_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    if (sh_count == 5'd1) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= sh_step_data;
                    end
                end
`endif
                ST_DONE: begin
                    if (accept) begin
                        state_reg     <= start_state;
                        out_valid_reg <= (start_state == ST_DONE);
                        result_reg    <= start_result;
                    end else if (outReady) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign outValid = out_valid_reg;
    assign result   = result_reg;

endmodule

// File: tb/tb_ialu_exec.sv
// Self-checking bench for ialu_exec: directed scenarios plus randomized ops against a reference model.
module tb_ialu_exec;
    import ialu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [4:0]  aluControl = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ialu_exec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inValid    (inValid),
        .inReady    (inReady),
        .aluControl (aluControl),
        .a          (a),
        .b          (b),
        .outValid   (outValid),
        .outReady   (outReady),
        .result     (result)
    );

    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        int sh;
        sh = int'(y[4:0]);
        case (op)
            ALU_CTL_ADD:    return x + y;
            ALU_CTL_SUB:    return x - y;
            ALU_CTL_AND:    return x & y;
            ALU_CTL_OR:     return x | y;
            ALU_CTL_XOR:    return x ^ y;
            ALU_CTL_SLT:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            ALU_CTL_SLTU:   return (x < y) ? 32'd1 : 32'd0;
            ALU_CTL_SLL:    return x << sh;
            ALU_CTL_SRL:    return x >> sh;
            ALU_CTL_SRA:    return $unsigned($signed(x) >>> sh);
            ALU_CTL_PASS_B: return y;
            default:        return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] y);
`ifdef IALU_BARREL_SHIFT_EN
        return 1;
`else
        if (op == ALU_CTL_SLL || op == ALU_CTL_SRL || op == ALU_CTL_SRA)
            return int'(y[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Issues one op from IDLE with outReady=1; reports latency, result and inReady-high cycles while busy.
    task automatic do_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] res, output int ready_high);
        ready_high = 0;
        aluControl = op; a = x; b = y; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        aluControl = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!outValid && lat < 100) begin
            if (inReady) ready_high++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=00000000", result); end
        #5 rst_n = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL reset_inReady got=%b exp=1", inReady); end
        @(posedge clk); #1;
        $display("reset: outValid=%b result=%h inReady=%b", outValid, result, inReady);
    endtask

    task automatic test_add_wrap();
        int lat, rh; logic [31:0] res;
        do_op(ALU_CTL_ADD, 32'hFFFF_FFFF, 32'd1, lat, res, rh);
        $display("add_wrap: lat=%0d result=%h", lat, res);
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL add_result got=%h exp=00000000", res); end
    endtask

    task automatic test_sra();
        int lat, rh, exp_lat; logic [31:0] res;
        exp_lat = ref_latency(ALU_CTL_SRA, 32'd4);
        do_op(ALU_CTL_SRA, 32'h8000_0000, 32'd4, lat, res, rh);
        $display("sra: lat=%0d result=%h", lat, res);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL sra_latency got=%0d exp=%0d", lat, exp_lat); end
        total++; if (res !== 32'hF800_0000) begin bad++; $display("FAIL sra_result got=%h exp=f8000000", res); end
        total++; if (rh !== 0) begin bad++; $display("FAIL sra_inReady_busy got=%0d cycles high exp=0", rh); end
    endtask

    task automatic test_compare();
        int lat, rh; logic [31:0] res;
        do_op(ALU_CTL_SLT, 32'hFFFF_FFFF, 32'd0, lat, res, rh);
        $display("slt: lat=%0d result=%h", lat, res);
        total++; if (res !== 32'd1) begin bad++; $display("FAIL slt_result got=%h exp=00000001", res); end
        do_op(ALU_CTL_SLTU, 32'hFFFF_FFFF, 32'd0, lat, res, rh);
        $display("sltu: lat=%0d result=%h", lat, res);
        total++; if (res !== 32'd0) begin bad++; $display("FAIL sltu_result got=%h exp=00000000", res); end
    endtask

    task automatic test_undefined();
        int lat, rh; logic [31:0] res;
        do_op(5'd31, 32'h1234, 32'h5678, lat, res, rh);
        $display("undef: lat=%0d result=%h", lat, res);
        total++; if (lat !== 1) begin bad++; $display("FAIL undef_latency got=%0d exp=1", lat); end
        total++; if (res !== 32'd0) begin bad++; $display("FAIL undef_result got=%h exp=00000000", res); end
    endtask

    task automatic test_shift_edges();
        int lat, rh, exp_lat; logic [31:0] res, x, exp_res;
        logic [4:0] sops[3];
        sops[0] = ALU_CTL_SLL; sops[1] = ALU_CTL_SRL; sops[2] = ALU_CTL_SRA;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 32; s += 31) begin
                x = $urandom | 32'h8000_0001;
                exp_res = ref_result(sops[i], x, 32'(s));
                exp_lat = ref_latency(sops[i], 32'(s));
                do_op(sops[i], x, 32'(s), lat, res, rh);
                $display("shift op=%0d a=%h sh=%0d lat=%0d result=%h", sops[i], x, s, lat, res);
                total++; if (lat !== exp_lat || res !== exp_res) begin
                    bad++; $display("FAIL shift_edge got lat=%0d res=%h exp lat=%0d res=%h", lat, res, exp_lat, exp_res);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, rh, exp_lat; logic [31:0] res, x, y, exp_res; logic [4:0] op;
        logic [4:0] ops[12];
        ops = '{ALU_CTL_ADD, ALU_CTL_SUB, ALU_CTL_AND, ALU_CTL_OR, ALU_CTL_XOR, ALU_CTL_SLT,
                ALU_CTL_SLTU, ALU_CTL_SLL, ALU_CTL_SRL, ALU_CTL_SRA, ALU_CTL_PASS_B, 5'd29};
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 11)];
            x = $urandom; y = $urandom;
            exp_res = ref_result(op, x, y);
            exp_lat = ref_latency(op, y);
            do_op(op, x, y, lat, res, rh);
            $display("rand op=%0d a=%h b=%h lat=%0d result=%h", op, x, y, lat, res);
            total++; if (lat !== exp_lat || res !== exp_res || rh !== 0) begin
                bad++; $display("FAIL rand_op got lat=%0d res=%h busy_ready=%0d exp lat=%0d res=%h", lat, res, rh, exp_lat, exp_res);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y, exp1, exp2;
        int held_bad;
        x = $urandom; y = $urandom; exp1 = x ^ y;
        aluControl = ALU_CTL_XOR; a = x; b = y; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0; a = $urandom; b = $urandom; aluControl = ALU_CTL_ADD;
        total++; if (outValid !== 1'b1 || result !== exp1) begin
            bad++; $display("FAIL hold_first got v=%b res=%h exp v=1 res=%h", outValid, result, exp1);
        end
        held_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (outValid !== 1'b1 || result !== exp1 || inReady !== 1'b0) held_bad++;
        end
        $display("hold: outValid=%b result=%h bad_cycles=%0d", outValid, result, held_bad);
        total++; if (held_bad !== 0) begin bad++; $display("FAIL hold_stable got=%0d bad cycles exp=0", held_bad); end
        x = $urandom; y = $urandom; exp2 = x + y;
        aluControl = ALU_CTL_ADD; a = x; b = y; inValid = 1'b1; outReady = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL b2b_inReady got=%b exp=1", inReady); end
        @(posedge clk); #1;
        inValid = 1'b0;
        $display("b2b: outValid=%b result=%h", outValid, result);
        total++; if (outValid !== 1'b1 || result !== exp2) begin
            bad++; $display("FAIL b2b_second got v=%b res=%h exp v=1 res=%h", outValid, result, exp2);
        end
        @(posedge clk); #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", outValid); end
    endtask

    task automatic test_reset_mid_shift();
        int stale;
        aluControl = ALU_CTL_SLL; a = $urandom | 32'h1; b = 32'd31; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL rst_mid_outValid got=%b exp=0", outValid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_mid_result got=%h exp=00000000", result); end
        #1 rst_n = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL rst_mid_inReady got=%b exp=1", inReady); end
        outReady = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (outValid !== 1'b0) stale++;
        end
        $display("reset_mid_shift: stale_valid_cycles=%0d", stale);
        total++; if (stale !== 0) begin bad++; $display("FAIL rst_mid_stale got=%0d exp=0", stale); end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sra();
        test_compare();
        test_undefined();
        test_shift_edges();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ialu_exec.md
IALU_EXEC -- requirements
Module: ialu_exec

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port inValid, input, 1 bit: an operation is presented.
REQ-004 The block SHALL have the port inReady, output, 1 bit: the block accepts an operation this cycle.
REQ-005 The block SHALL have the port aluControl, input, 5 bits: the operation code, as produced by the ALU control decoder.
REQ-006 The block SHALL have the ports a and b, input, 32 bits each: the operands; b[4:0] is the shift amount.
REQ-007 The block SHALL have the port outValid, output, 1 bit: result is valid.
REQ-008 The block SHALL have the port outReady, input, 1 bit: the consumer takes the result.
REQ-009 The block SHALL have the port result, output, 32 bits: the operation result.

Function
REQ-010 The block SHALL accept an operation on a cycle with inValid && inReady, and SHALL capture aluControl, a and b on that edge.
REQ-011 The block SHALL drive inReady high in IDLE, and in DONE when outReady is high (back-to-back issue); otherwise inReady SHALL be low.
REQ-012 The block SHALL implement three states: IDLE, SHIFT and DONE.
- IDLE: on accept of a non-shift op -> DONE; on a shift op with shamt>0 -> SHIFT; on a shift op with shamt=0 -> DONE with result=a.
- SHIFT: one bit position per cycle; count decrements; at count=1 -> DONE.
- DONE: when outReady is high -> IDLE, or to the next op if one is accepted on the same edge.
REQ-013 The block SHALL implement the following operations:
- ADD, SUB: modulo 2^32.
- AND, OR, XOR.
- SLT: signed compare, result 1 or 0.
- SLTU: unsigned compare, result 1 or 0.
- SLL, SRL: zero fill.
- SRA: sign fill.
- PASS_B: result=b (LUI).
REQ-014 The block SHALL complete non-shift ops with latency 1: outValid rises on the cycle after accept.
REQ-015 The block SHALL complete shift ops with latency shamt+1 cycles; shamt=0 SHALL give latency 1.
REQ-016 The block SHALL assert outValid only in DONE, and SHALL hold result and outValid stable while outValid && !outReady.
REQ-017 The block SHALL produce result=0 for an undefined aluControl code, with latency 1 and no error flag.
REQ-018 The block SHALL ignore changes on inputs while not accepting, including during SHIFT.

Reset
REQ-019 While rst_n is low, the block SHALL force state=IDLE, outValid=0, result=0 and count=0 immediately, independent of clk.
REQ-020 A reset during SHIFT or DONE SHALL discard the in-flight operation, and the block SHALL NOT produce any result for it after release.
REQ-021 After reset release, inReady SHALL be 1.

Configuration
REQ-022 When IALU_BARREL_SHIFT_EN is defined, the block SHALL complete all shifts in one cycle with a barrel shifter (latency 1), and SHALL never enter SHIFT.
REQ-023 When IALU_BARREL_SHIFT_EN is undefined, the block SHALL use the serial shifter of REQ-012/REQ-015.

Structure
REQ-024 The aluControl operation codes and the state encodings SHALL reside in the shared core definitions header, together with the ALU control decoder codes; ialu_exec SHALL NOT use local literals for them.
REQ-025 The serial shifter (data register, count, direction, fill bit) SHALL be a sub-module named ialu_shifter; the ALU datapath and FSM SHALL remain in ialu_exec.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- ADD a=0xFFFFFFFF b=1, outReady=1 -> outValid on the next cycle, result=0x00000000.
- SRA a=0x80000000 b=4 (serial build) -> outValid 5 cycles after accept, result=0xF8000000; inReady=0 throughout SHIFT.
- SLT a=0xFFFFFFFF b=0 -> result=1; SLTU with the same operands -> result=0.
- DONE with outReady=0 for 3 cycles -> result and outValid held; outReady=1 together with a new inValid -> the new op is accepted on the same edge.
- rst_n pulsed low during SLL shamt=31 -> outValid=0 and result=0 at once; after release inReady=1 and no stale result appears.
- Undefined aluControl code, a=0x1234, b=0x5678 -> result=0 after 1 cycle; rerun the shift tests with IALU_BARREL_SHIFT_EN -> all latencies=1.
